// File: rtl/hbridge_square_gen_pkg.sv
// Shared types, limits and switch-pattern helper for the H-bridge carrier generator.
package hbridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [3:0] MOS_OFF = 4'b0000;

    localparam int PERIOD_W_DEF       = 32;
    localparam int PERIOD_MIN_DEF     = 50;
    localparam int PERIOD_MAX_DEF     = 5000;
    localparam int PERIOD_DEFAULT_DEF = 500;

    // Diagonal pairs only: Q1/Q4 together, Q2/Q3 together, never a full leg.
    function automatic logic [3:0] mos_pattern(input logic sigma);
        return {sigma, ~sigma, ~sigma, sigma};
    endfunction

endpackage

// File: rtl/hbridge_square_gen_if.sv
// Control/status bundle between frequency_control, the carrier generator and dead_time_4bit.
interface hbridge_square_gen_if
    import hbridge_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
);
    logic                i_enable;
    logic [PERIOD_W-1:0] i_period;
    logic                i_period_valid;
    logic [3:0]          o_mosfet;
    logic                o_sigma;
    logic                o_running;
    logic                o_cycle_start;
    logic [PERIOD_W-1:0] o_period_active;
    logic                o_period_err;

    modport master (
        output i_enable, i_period, i_period_valid,
        input  o_mosfet, o_sigma, o_running, o_cycle_start, o_period_active, o_period_err
    );

    modport slave (
        input  i_enable, i_period, i_period_valid,
        output o_mosfet, o_sigma, o_running, o_cycle_start, o_period_active, o_period_err
    );
endinterface

// File: rtl/hbridge_square_gen_period_reg.sv
// Half-period request path: range check, shadow register, error pulse and load of the active value.
module hbridge_period_reg
    import hbridge_pkg::*;
#(
    parameter int PERIOD_W       = PERIOD_W_DEF,
    parameter int PERIOD_MIN     = PERIOD_MIN_DEF,
    parameter int PERIOD_MAX     = PERIOD_MAX_DEF,
    parameter int PERIOD_DEFAULT = PERIOD_DEFAULT_DEF
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_period_valid,
    input  logic                i_load,
    output logic [PERIOD_W-1:0] o_active,
    output logic                o_period_err
);
    localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] P_MAX = PERIOD_W'(PERIOD_MAX);
    localparam logic [PERIOD_W-1:0] P_DEF = PERIOD_W'(PERIOD_DEFAULT);

    logic [PERIOD_W-1:0] shadow;
    logic                in_range;

    assign in_range = (i_period >= P_MIN) && (i_period <= P_MAX);

    // active takes the pre-edge shadow, so a request on the load cycle waits for the next load.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shadow       <= P_DEF;
            o_active     <= P_DEF;
            o_period_err <= 1'b0;
        end else begin
            o_period_err <= i_period_valid & ~in_range;
            if (i_period_valid && in_range) shadow <= i_period;
            if (i_load) o_active <= shadow;
        end
    end
endmodule

// File: rtl/hbridge_square_gen.sv
// Square-wave carrier generator for the full H-bridge with start/stop and cycle-aligned period updates.
//   state | meaning
//   IDLE  | all switches off, counter held at 0
//   RUN   | switching, enable high
//   STOP  | switching until the current full cycle wraps, then IDLE
module hbridge_square_gen
    import hbridge_pkg::*;
#(
    parameter int PERIOD_W       = PERIOD_W_DEF,
    parameter int PERIOD_MIN     = PERIOD_MIN_DEF,
    parameter int PERIOD_MAX     = PERIOD_MAX_DEF,
    parameter int PERIOD_DEFAULT = PERIOD_DEFAULT_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    hbridge_square_gen_if.slave  bus
);
    localparam int CNT_W = PERIOD_W + 1;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, wrap_cnt;
    logic [PERIOD_W-1:0] active;
    logic                load, wrap, running, sigma;

    hbridge_period_reg #(
        .PERIOD_W      (PERIOD_W),
        .PERIOD_MIN    (PERIOD_MIN),
        .PERIOD_MAX    (PERIOD_MAX),
        .PERIOD_DEFAULT(PERIOD_DEFAULT)
    ) u_period_reg (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_period      (bus.i_period),
        .i_period_valid(bus.i_period_valid),
        .i_load        (load),
        .o_active      (active),
        .o_period_err  (bus.o_period_err)
    );

    assign wrap_cnt = {active, 1'b0} - CNT_W'(1);
    assign wrap     = (cnt == wrap_cnt);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wrap ? '0 : cnt + CNT_W'(1);
        load      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.i_enable) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                load = wrap;
                if (!bus.i_enable) state_nxt = STOP;
            end
            STOP: begin
                load = wrap;
                if (wrap) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign running              = (state != IDLE);
    assign sigma                = running && (cnt >= {1'b0, active});
    assign bus.o_running        = running;
    assign bus.o_sigma          = sigma;
    assign bus.o_mosfet         = running ? mos_pattern(sigma) : MOS_OFF;
    assign bus.o_cycle_start    = running && (cnt == '0);
    assign bus.o_period_active  = active;
endmodule

// File: tb/tb_hbridge_square_gen.sv
// Scoreboard bench: stimulus queues expected cycle starts and error pulses, a negedge monitor checks them.
module tb_hbridge_square_gen;
    import hbridge_pkg::*;

    typedef struct {
        int          edge_no;
        logic [31:0] period;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t cs_q[$];
    int   err_q[$];
    exp_t cs_e;
    int   err_e;
    int   c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c12;

    hbridge_square_gen_if #(.PERIOD_W(32)) bus ();

    hbridge_square_gen dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic write_period(input logic [31:0] v);
        bus.i_period       = v;
        bus.i_period_valid = 1'b1;
        @(negedge clk);
        bus.i_period_valid = 1'b0;
    endtask

    task automatic push_cs(input int n, input logic [31:0] p);
        exp_t e;
        e.edge_no = n;
        e.period  = p;
        cs_q.push_back(e);
    endtask

    always @(negedge clk) begin
        checks++;
        if (!(bus.o_mosfet inside {4'b0000, 4'b0110, 4'b1001})) begin
            errors++;
            $display("FAIL mosfet_legal at edge %0d: got %b", edge_cnt, bus.o_mosfet);
        end
        if (bus.o_cycle_start) begin
            if (cs_q.size() == 0) begin
                chk("cycle_start_unexpected", 32'd1, 32'd0);
            end else begin
                cs_e = cs_q.pop_front();
                chk("cycle_start_edge", edge_cnt, cs_e.edge_no);
                chk("cycle_start_period", bus.o_period_active, cs_e.period);
                chk("cycle_start_mosfet", {28'd0, bus.o_mosfet}, 32'h6);
            end
        end
        if (bus.o_period_err) begin
            if (err_q.size() == 0) begin
                chk("period_err_unexpected", 32'd1, 32'd0);
            end else begin
                err_e = err_q.pop_front();
                chk("period_err_edge", edge_cnt, err_e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.i_enable       = 1'b0;
        bus.i_period       = '0;
        bus.i_period_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mosfet", {28'd0, bus.o_mosfet}, 32'h0);
        chk("rst_running", {31'd0, bus.o_running}, 32'd0);
        chk("rst_sigma", {31'd0, bus.o_sigma}, 32'd0);
        chk("rst_cycle_start", {31'd0, bus.o_cycle_start}, 32'd0);
        chk("rst_period_err", {31'd0, bus.o_period_err}, 32'd0);
        chk("rst_period_active", bus.o_period_active, 32'd500);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_running", {31'd0, bus.o_running}, 32'd0);

        // default 500-clock half period
        c0 = edge_cnt + 1;
        bus.i_enable = 1'b1;
        push_cs(c0, 500);
        push_cs(c0 + 1000, 500);
        wait_to(c0);
        chk("t1_first_mosfet", {28'd0, bus.o_mosfet}, 32'h6);
        chk("t1_first_running", {31'd0, bus.o_running}, 32'd1);
        wait_to(c0 + 499);
        chk("t1_low_end", {28'd0, bus.o_mosfet}, 32'h6);
        wait_to(c0 + 500);
        chk("t1_high_start", {28'd0, bus.o_mosfet}, 32'h9);
        chk("t1_sigma_high", {31'd0, bus.o_sigma}, 32'd1);
        wait_to(c0 + 999);
        chk("t1_high_end", {28'd0, bus.o_mosfet}, 32'h9);

        // mid-cycle update to 200
        c1 = c0 + 1000;
        c2 = c1 + 1000;
        c3 = c2 + 400;
        wait_to(c1 + 300);
        push_cs(c2, 200);
        push_cs(c3, 200);
        write_period(200);
        wait_to(c1 + 999);
        chk("t2_active_before_wrap", bus.o_period_active, 32'd500);
        wait_to(c2);
        chk("t2_active_after_wrap", bus.o_period_active, 32'd200);
        wait_to(c2 + 199);
        chk("t2_low_end", {28'd0, bus.o_mosfet}, 32'h6);
        wait_to(c2 + 200);
        chk("t2_high_start", {28'd0, bus.o_mosfet}, 32'h9);

        // out-of-range requests
        c4 = c3 + 400;
        c5 = c4 + 400;
        push_cs(c4, 200);
        push_cs(c5, 200);
        wait_to(c3 + 50);
        err_q.push_back(c3 + 51);
        write_period(10);
        wait_to(c3 + 100);
        err_q.push_back(c3 + 101);
        write_period(6000);
        wait_to(c3 + 150);
        chk("t3_active_unchanged", bus.o_period_active, 32'd200);

        // stop at cnt=300 of a 1000-clock cycle, re-enable during STOP
        c6 = c5 + 400;
        c7 = c6 + 1001;
        wait_to(c5 + 10);
        push_cs(c6, 500);
        write_period(500);
        wait_to(c6 + 300);
        chk("t4_at_300", {28'd0, bus.o_mosfet}, 32'h6);
        bus.i_enable = 1'b0;
        wait_to(c6 + 800);
        chk("t4_stop_running", {31'd0, bus.o_running}, 32'd1);
        bus.i_enable = 1'b1;
        push_cs(c7, 500);
        wait_to(c6 + 999);
        chk("t4_last_switch", {28'd0, bus.o_mosfet}, 32'h9);
        chk("t4_last_running", {31'd0, bus.o_running}, 32'd1);
        wait_to(c6 + 1000);
        chk("t4_idle_mosfet", {28'd0, bus.o_mosfet}, 32'h0);
        chk("t4_idle_running", {31'd0, bus.o_running}, 32'd0);
        wait_to(c7);
        chk("t4_restart_mosfet", {28'd0, bus.o_mosfet}, 32'h6);

        // reset in the second half loses a pending shadow value
        wait_to(c7 + 100);
        write_period(300);
        wait_to(c7 + 700);
        chk("t5_pre_reset_sigma", {31'd0, bus.o_sigma}, 32'd1);
        rst = 1'b1;
        wait_to(c7 + 701);
        chk("t5_reset_mosfet", {28'd0, bus.o_mosfet}, 32'h0);
        chk("t5_reset_running", {31'd0, bus.o_running}, 32'd0);
        chk("t5_reset_active", bus.o_period_active, 32'd500);
        wait_to(c7 + 705);
        rst = 1'b0;
        c8 = c7 + 706;
        c9 = c8 + 1000;
        push_cs(c8, 500);
        push_cs(c9, 500);
        wait_to(c8);
        chk("t5_restart_mosfet", {28'd0, bus.o_mosfet}, 32'h6);

        // minimum half period
        c10 = c9 + 1000;
        c12 = c10 + 200;
        wait_to(c9 + 10);
        push_cs(c10, 50);
        push_cs(c10 + 100, 50);
        push_cs(c12, 50);
        write_period(50);
        wait_to(c10 + 49);
        chk("t6_low_end", {28'd0, bus.o_mosfet}, 32'h6);
        wait_to(c10 + 50);
        chk("t6_high_start", {28'd0, bus.o_mosfet}, 32'h9);
        chk("t6_active", bus.o_period_active, 32'd50);
        wait_to(c12 + 10);
        bus.i_enable = 1'b0;
        wait_to(c12 + 99);
        chk("t6_stop_running", {31'd0, bus.o_running}, 32'd1);
        wait_to(c12 + 100);
        chk("t6_idle_running", {31'd0, bus.o_running}, 32'd0);
        chk("t6_idle_mosfet", {28'd0, bus.o_mosfet}, 32'h0);
        wait_to(c12 + 120);
        chk("cycle_start_q_drained", cs_q.size(), 32'd0);
        chk("period_err_q_drained", err_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
